spi_slave_regfile: RTL

SPI_SLAVE_REGFILE -- requirements
Module: spi_slave_regfile

---
 rtl/spi_slave_regfile_pkg.sv | 15 +
 rtl/spi_sync_edge.sv | 55 +++++
 rtl/spi_slave_regfile.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_regfile_pkg.sv
// Shared types and constants for the SPI slave register file.
// Used by spi_slave_regfile; optional burst mode via SPI_SLV_BURST_EN.
package spi_slave_regfile_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t CMD  = 2'd1;
    localparam state_t DATA = 2'd2;
    localparam state_t HOLD = 2'd3;

    localparam logic CMD_WR = 1'b1;
    localparam logic CMD_RD = 1'b0;

endpackage

// File: rtl/spi_sync_edge.sv
// Brings SS/SCLK/MOSI into the CLK domain and turns SCLK
// transitions into one-cycle sample/shift strobes for the chosen mode.
module spi_sync_edge #(
    parameter int CPOL = 0,
    parameter int CPHA = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic ss_in,
    input  logic sclk_in,
    input  logic mosi_in,
    output logic ss_n,
    output logic mosi,
    output logic sample_stb,
    output logic shift_stb
);

    localparam logic IDLE_LVL = (CPOL != 0);
    localparam bit   LATE     = (CPHA != 0);

    logic [1:0] ss_q;
    logic [1:0] sclk_q;
    logic [1:0] mosi_q;
    logic       sclk_d;
    logic       rise;
    logic       fall;
    logic       lead;
    logic       trail;

    // Two-flop synchronisers plus one delayed SCLK copy for edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_q   <= 2'b11;
            sclk_q <= {2{IDLE_LVL}};
            mosi_q <= 2'b00;
            sclk_d <= IDLE_LVL;
        end else begin
            ss_q   <= {ss_q[0], ss_in};
            sclk_q <= {sclk_q[0], sclk_in};
            mosi_q <= {mosi_q[0], mosi_in};
            sclk_d <= sclk_q[1];
        end
    end

    assign ss_n  = ss_q[1];
    assign mosi  = mosi_q[1];
    assign rise  = sclk_q[1] & ~sclk_d;
    assign fall  = ~sclk_q[1] & sclk_d;
    assign lead  = IDLE_LVL ? fall : rise;
    assign trail = IDLE_LVL ? rise : fall;

    assign sample_stb = LATE ? trail : lead;
    assign shift_stb  = LATE ? lead : trail;

endmodule

// File: rtl/spi_slave_regfile.sv
// SPI slave with a 2**A x D register file, CLK-domain only.
// Define SPI_SLV_BURST_EN for auto-incrementing multi-word frames.
module spi_slave_regfile
    import spi_slave_regfile_pkg::*;
#(
    parameter int D    = 8,
    parameter int A    = 8,
    parameter int CPOL = 0,
    parameter int CPHA = 0
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         SS,
    input  logic         SCLK,
    input  logic         MOSI,
    output logic         MISO,
    output logic         MISO_OE,
    output logic         WR_STB,
    output logic [A-1:0] WR_ADDR,
    output logic [D-1:0] WR_DATA,
    output logic         ABORT
);

    localparam int NW   = 2 ** A;
    localparam int CMAX = (A > D) ? A : D;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] HDR_LAST = CW'(A);
    localparam logic [CW-1:0] DAT_LAST = CW'(D - 1);

    logic          ss_n;
    logic          mosi;
    logic          sample_stb;
    logic          shift_stb;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [A:0]    hdr;
    logic [A:0]    hdr_nxt;
    logic          cmd_q;
    logic [A-1:0]  addr;
    logic [D-1:0]  rx;
    logic [D-1:0]  rx_nxt;
    logic [D-1:0]  tx;
    logic [1:0]    settle;
    logic          armed;
    logic          commit;
    logic [D-1:0]  regs [NW];

`ifdef SPI_SLV_BURST_EN
    logic [A-1:0]  addr_inc;
    assign addr_inc = addr + 1'b1;
`endif

    spi_sync_edge #(
        .CPOL(CPOL),
        .CPHA(CPHA)
    ) u_sync (
        .clk       (CLK),
        .rst       (RST),
        .ss_in     (SS),
        .sclk_in   (SCLK),
        .mosi_in   (MOSI),
        .ss_n      (ss_n),
        .mosi      (mosi),
        .sample_stb(sample_stb),
        .shift_stb (shift_stb)
    );

    assign MISO_OE = ~ss_n;
    assign hdr_nxt = (A + 1)'({hdr, mosi});
    assign rx_nxt  = D'({rx, mosi});

    assign commit = (state == DATA) && !ss_n && sample_stb &&
                    (cnt == DAT_LAST) && (cmd_q == CMD_WR);

    // Register array and the one-cycle write report
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NW; i++) begin
                regs[i] <= '0;
            end
            WR_STB  <= 1'b0;
            WR_ADDR <= '0;
            WR_DATA <= '0;
        end else begin
            WR_STB <= commit;
            if (commit) begin
                regs[addr] <= rx_nxt;
                WR_ADDR    <= addr;
                WR_DATA    <= rx_nxt;
            end
        end
    end

    // Frame sequencer: header capture, data shift in/out, abort on early SS rise
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            cnt    <= '0;
            hdr    <= '0;
            cmd_q  <= CMD_RD;
            addr   <= '0;
            rx     <= '0;
            tx     <= '0;
            MISO   <= 1'b0;
            ABORT  <= 1'b0;
            settle <= 2'b00;
            armed  <= 1'b0;
        end else begin
            ABORT  <= 1'b0;
            settle <= {settle[0], 1'b1};
            if (settle[1] && ss_n) begin
                armed <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    MISO <= 1'b0;
                    if (armed && !ss_n) begin
                        state <= CMD;
                        cnt   <= '0;
                        hdr   <= '0;
                    end
                end
                CMD: begin
                    if (ss_n) begin
                        state <= IDLE;
                        ABORT <= 1'b1;
                    end else if (sample_stb) begin
                        hdr <= hdr_nxt;
                        if (cnt == HDR_LAST) begin
                            state <= DATA;
                            cnt   <= '0;
                            cmd_q <= hdr_nxt[A];
                            addr  <= hdr_nxt[A-1:0];
                            rx    <= '0;
                            tx    <= (hdr_nxt[A] == CMD_RD) ?
                                     regs[hdr_nxt[A-1:0]] : '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (ss_n) begin
                        state <= IDLE;
                        ABORT <= 1'b1;
                        MISO  <= 1'b0;
                    end else begin
                        if (shift_stb) begin
                            MISO <= tx[D-1];
                            tx   <= tx << 1;
                        end
                        if (sample_stb) begin
                            rx <= rx_nxt;
                            if (cnt == DAT_LAST) begin
                                cnt <= '0;
`ifdef SPI_SLV_BURST_EN
                                addr <= addr_inc;
                                tx   <= (cmd_q == CMD_RD) ?
                                        regs[addr_inc] : '0;
`else
                                state <= HOLD;
                                MISO  <= 1'b0;
`endif
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                end
                HOLD: begin
                    MISO <= 1'b0;
                    if (ss_n) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
